// File: rtl/bp_io_host_arbiter.sv
// ----------------------------------------------------------------------------
// bp_io_host_arbiter
//
// Lets num_req_p requesters share the single host I/O command/response port.
// Commands are picked round-robin and placed in a one-entry registered output
// stage. The owner of every issued command goes into an in-order tag FIFO. The
// host answers in order, so the FIFO head always names the requester that
// owns the current response.
//
// Ports
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   req_cmd_i/_v_i        per-requester command (slice r) and valid
//   req_cmd_yumi_o        one-hot (or zero) command accept
//   req_resp_o            host response data, broadcast to all requesters
//   req_resp_v_o          one-hot (or zero) response valid
//   req_resp_ready_i      per-requester response ready
//   io_cmd_o/_v_o         registered command to host, valid
//   io_cmd_ready_i        host accepts the command (valid-ready)
//   io_resp_i/_v_i        host response and valid
//   io_resp_yumi_o        response consumed
//   idle_o                output stage empty and no command outstanding
//   err_o                 sticky: response arrived with nothing outstanding
// ----------------------------------------------------------------------------
module bp_io_host_arbiter #(
    parameter int num_req_p         = 4,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,

    input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]             req_cmd_v_i,
    output logic [num_req_p-1:0]             req_cmd_yumi_o,

    output logic [msg_width_p-1:0]           req_resp_o,
    output logic [num_req_p-1:0]             req_resp_v_o,
    input  logic [num_req_p-1:0]             req_resp_ready_i,

    output logic [msg_width_p-1:0]           io_cmd_o,
    output logic                             io_cmd_v_o,
    input  logic                             io_cmd_ready_i,

    input  logic [msg_width_p-1:0]           io_resp_i,
    input  logic                             io_resp_v_i,
    output logic                             io_resp_yumi_o,

    output logic                             idle_o,
    output logic                             err_o
);

    localparam int tag_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);

    typedef logic [tag_width_lp-1:0] tag_t;
    typedef logic [ptr_width_lp-1:0] ptr_t;
    typedef logic [cnt_width_lp-1:0] cnt_t;

    // Output stage and arbitration state
    logic [msg_width_p-1:0] cmd_r;
    logic                   cmd_v_r;
    tag_t                   last_r;

    // Tag FIFO
    tag_t tag_mem [max_outstanding_p];
    ptr_t wr_ptr_r;
    ptr_t rd_ptr_r;
    cnt_t count_r;
    logic err_r;

    logic tag_full;
    logic tag_empty;
    tag_t head;

    logic can_load;
    logic drain;
    logic grant_v;
    tag_t grant_idx;
    logic grant_fire;
    logic resp_live;
    int   idx;

    function automatic ptr_t ptr_next(ptr_t p);
        return (p == ptr_t'(max_outstanding_p - 1)) ? '0 : ptr_t'(p + ptr_t'(1));
    endfunction

    assign tag_full  = (count_r == cnt_t'(max_outstanding_p));
    assign tag_empty = (count_r == '0);
    assign head      = tag_mem[rd_ptr_r];

    // A full FIFO blocks the grant even when a response pops in the same cycle.
    assign drain    = cmd_v_r & io_cmd_ready_i;
    assign can_load = (~cmd_v_r | io_cmd_ready_i) & ~tag_full;

    // Gating with reset keeps yumi low while reset is asserted, even though
    // the stage reads as free then.
    assign grant_fire = grant_v & can_load & reset_n_i;

    // Round-robin search starting one past the last grant. Walking the offsets
    // from farthest to nearest lets the nearest valid requester win last.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = num_req_p; i >= 1; i--) begin
            idx = (int'(last_r) + i) % num_req_p;
            if (req_cmd_v_i[tag_t'(idx)]) begin
                grant_v   = 1'b1;
                grant_idx = tag_t'(idx);
            end
        end
    end

    // Responses route purely combinationally to the requester at the head.
    assign resp_live      = io_resp_v_i & ~tag_empty;
    assign io_resp_yumi_o = resp_live & req_resp_ready_i[head];
    assign req_resp_o     = io_resp_i;

    always_comb begin
        req_cmd_yumi_o = '0;
        req_resp_v_o   = '0;
        for (int r = 0; r < num_req_p; r++) begin
            req_cmd_yumi_o[r] = grant_fire && (grant_idx == tag_t'(r));
            req_resp_v_o[r]   = resp_live && (head == tag_t'(r));
        end
    end

    assign io_cmd_o   = cmd_r;
    assign io_cmd_v_o = cmd_v_r;
    assign idle_o     = ~cmd_v_r & tag_empty;
    assign err_o      = err_r;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_v_r  <= 1'b0;
            last_r   <= tag_t'(num_req_p - 1);
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            if (grant_fire) begin
                cmd_v_r <= 1'b1;
                last_r  <= grant_idx;
            end else if (drain) begin
                cmd_v_r <= 1'b0;
            end

            if (grant_fire) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (io_resp_yumi_o) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end

            unique case ({grant_fire, io_resp_yumi_o})
                2'b10:   count_r <= count_r + cnt_t'(1);
                2'b01:   count_r <= count_r - cnt_t'(1);
                default: count_r <= count_r;
            endcase

            if (io_resp_v_i && tag_empty) begin
                err_r <= 1'b1;
            end
        end
    end

    // NOTE: the command payload and tag storage carry no reset; their
    // contents are only looked at while cmd_v_r or count_r says they are live.
    always_ff @(posedge clk_i) begin
        if (grant_fire) begin
            cmd_r             <= req_cmd_i[grant_idx*msg_width_p +: msg_width_p];
            tag_mem[wr_ptr_r] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_bp_io_host_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bp_io_host_arbiter
//
// Self-checking bench for bp_io_host_arbiter (4 requesters, 128-bit messages,
// 4 outstanding). A queue-based model of the output stage, tag FIFO and host
// predicts every cycle's outputs; scenario tasks add directed checks on top.
// ----------------------------------------------------------------------------
module tb_bp_io_host_arbiter;

    localparam int NR = 4;
    localparam int MW = 128;
    localparam int MO = 4;

    logic              clk_i = 1'b0;
    logic              reset_n_i = 1'b0;
    logic [NR*MW-1:0]  req_cmd_i = '0;
    logic [NR-1:0]     req_cmd_v_i = '0;
    logic [NR-1:0]     req_cmd_yumi_o;
    logic [MW-1:0]     req_resp_o;
    logic [NR-1:0]     req_resp_v_o;
    logic [NR-1:0]     req_resp_ready_i = '0;
    logic [MW-1:0]     io_cmd_o;
    logic              io_cmd_v_o;
    logic              io_cmd_ready_i = 1'b0;
    logic [MW-1:0]     io_resp_i = '0;
    logic              io_resp_v_i = 1'b0;
    logic              io_resp_yumi_o;
    logic              idle_o;
    logic              err_o;

    bp_io_host_arbiter #(
        .num_req_p        (NR),
        .msg_width_p      (MW),
        .max_outstanding_p(MO)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .req_cmd_i       (req_cmd_i),
        .req_cmd_v_i     (req_cmd_v_i),
        .req_cmd_yumi_o  (req_cmd_yumi_o),
        .req_resp_o      (req_resp_o),
        .req_resp_v_o    (req_resp_v_o),
        .req_resp_ready_i(req_resp_ready_i),
        .io_cmd_o        (io_cmd_o),
        .io_cmd_v_o      (io_cmd_v_o),
        .io_cmd_ready_i  (io_cmd_ready_i),
        .io_resp_i       (io_resp_i),
        .io_resp_v_i     (io_resp_v_i),
        .io_resp_yumi_o  (io_resp_yumi_o),
        .idle_o          (idle_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    // Stimulus knobs set by the scenario tasks
    logic [NR-1:0] req_v    = '0;
    logic          cmd_rdy  = 1'b0;
    logic          resp_en  = 1'b0;
    logic [NR-1:0] resp_rdy = '1;
    logic          orphan   = 1'b0;
    int            seq      = 0;

    // Model state: output stage, outstanding owners, host's pending replies
    logic [MW-1:0] cmd_q[$];
    int            tag_q[$];
    logic [MW-1:0] host_q[$];
    int            tb_last = NR - 1;
    logic          tb_err  = 1'b0;

    localparam logic [MW-1:0] RESP_MASK = {4{32'h5A5A_0F0F}};

    function automatic logic [MW-1:0] make_cmd(int r, int s);
        return {r[31:0], s[31:0], 32'hDEAD_BEEF, 32'(r * 7 + s)};
    endfunction

    task automatic model_reset();
        cmd_q.delete();
        tag_q.delete();
        host_q.delete();
        tb_last = NR - 1;
        tb_err  = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict and compare at the falling edge,
    // advance the model, return 1 ns after the rising edge. obs_g reports the
    // requester the DUT accepted (-1 for none) for the scenario checks.
    task automatic sb_cycle(output int obs_g);
        logic [NR-1:0] exp_yumi;
        logic [NR-1:0] exp_rv;
        logic          exp_ryumi;
        logic          stage_v;
        logic          can_load;
        logic          orphan_now;
        int            g;
        int            owner;

        for (int r = 0; r < NR; r++) begin
            req_cmd_i[r*MW +: MW] = make_cmd(r, seq);
        end
        req_cmd_v_i      = req_v;
        io_cmd_ready_i   = cmd_rdy;
        req_resp_ready_i = resp_rdy;
        if (orphan) begin
            io_resp_v_i = 1'b1;
            io_resp_i   = make_cmd(9, seq);
        end else if (resp_en && host_q.size() > 0) begin
            io_resp_v_i = 1'b1;
            io_resp_i   = host_q[0] ^ RESP_MASK;
        end else begin
            io_resp_v_i = 1'b0;
            io_resp_i   = '0;
        end

        @(negedge clk_i);

        stage_v  = (cmd_q.size() > 0);
        can_load = (!stage_v || cmd_rdy) && (tag_q.size() < MO);
        g = -1;
        if (can_load) begin
            for (int k = 1; k <= NR; k++) begin
                if (g < 0 && req_v[(tb_last + k) % NR]) g = (tb_last + k) % NR;
            end
        end
        exp_yumi = '0;
        if (g >= 0) exp_yumi[g] = 1'b1;

        exp_rv     = '0;
        exp_ryumi  = 1'b0;
        orphan_now = 1'b0;
        owner      = -1;
        if (io_resp_v_i) begin
            if (tag_q.size() > 0) begin
                owner         = tag_q[0];
                exp_rv[owner] = 1'b1;
                exp_ryumi     = resp_rdy[owner];
            end else begin
                orphan_now = 1'b1;
            end
        end

        total++;
        if (req_cmd_yumi_o !== exp_yumi) begin
            bad++;
            $display("FAIL cmd_yumi @%0t: got %b want %b", $time, req_cmd_yumi_o, exp_yumi);
        end
        total++;
        if (io_cmd_v_o !== stage_v) begin
            bad++;
            $display("FAIL io_cmd_v @%0t: got %b want %b", $time, io_cmd_v_o, stage_v);
        end
        if (stage_v) begin
            total++;
            if (io_cmd_o !== cmd_q[0]) begin
                bad++;
                $display("FAIL io_cmd @%0t: got %h want %h", $time, io_cmd_o, cmd_q[0]);
            end
        end
        total++;
        if (req_resp_v_o !== exp_rv) begin
            bad++;
            $display("FAIL resp_v @%0t: got %b want %b", $time, req_resp_v_o, exp_rv);
        end
        total++;
        if (io_resp_yumi_o !== exp_ryumi) begin
            bad++;
            $display("FAIL resp_yumi @%0t: got %b want %b", $time, io_resp_yumi_o, exp_ryumi);
        end
        if (io_resp_v_i) begin
            total++;
            if (req_resp_o !== io_resp_i) begin
                bad++;
                $display("FAIL resp_data @%0t: got %h want %h", $time, req_resp_o, io_resp_i);
            end
        end
        total++;
        if (idle_o !== (cmd_q.size() == 0 && tag_q.size() == 0)) begin
            bad++;
            $display("FAIL idle @%0t: got %b want %b", $time, idle_o,
                     (cmd_q.size() == 0 && tag_q.size() == 0));
        end
        total++;
        if (err_o !== tb_err) begin
            bad++;
            $display("FAIL err @%0t: got %b want %b", $time, err_o, tb_err);
        end

        obs_g = -1;
        for (int r = 0; r < NR; r++) begin
            if (req_cmd_yumi_o[r] === 1'b1) obs_g = r;
        end

        if (exp_ryumi) begin
            void'(tag_q.pop_front());
            if (host_q.size() > 0) void'(host_q.pop_front());
        end
        if (stage_v && cmd_rdy) host_q.push_back(cmd_q.pop_front());
        if (g >= 0) begin
            cmd_q.push_back(make_cmd(g, seq));
            tag_q.push_back(g);
            tb_last = g;
        end
        if (orphan_now) tb_err = 1'b1;
        seq++;

        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            total++;
            if (idle_o !== 1'b1 || io_cmd_v_o !== 1'b0 || req_cmd_yumi_o !== '0 ||
                req_resp_v_o !== '0 || io_resp_yumi_o !== 1'b0 || err_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: got idle=%b cmd_v=%b yumi=%b rv=%b ryumi=%b err=%b want 1 0 0000 0000 0 0",
                         idle_o, io_cmd_v_o, req_cmd_yumi_o, req_resp_v_o, io_resp_yumi_o, err_o);
            end
        end
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        total++;
        if (idle_o !== 1'b1 || io_cmd_v_o !== 1'b0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got idle=%b cmd_v=%b err=%b want 1 0 0",
                     idle_o, io_cmd_v_o, err_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(int cycles);
        int g;
        req_v   = '0;
        cmd_rdy = 1'b1;
        resp_en = 1'b1;
        for (int c = 0; c < cycles; c++) sb_cycle(g);
    endtask

    task automatic test_fairness();
        int g;
        req_v    = '1;
        cmd_rdy  = 1'b1;
        resp_en  = 1'b1;
        resp_rdy = '1;
        for (int c = 0; c < 12; c++) begin
            sb_cycle(g);
            total++;
            if (g !== c % NR) begin
                bad++;
                $display("FAIL rr_order cycle %0d: got %0d want %0d", c, g, c % NR);
            end
        end
        drain(4);
    endtask

    task automatic test_backpressure();
        int g;
        int grants;
        req_v   = 4'b0100;
        cmd_rdy = 1'b0;
        resp_en = 1'b1;
        grants  = 0;
        for (int c = 0; c < 5; c++) begin
            sb_cycle(g);
            if (g >= 0) grants++;
        end
        total++;
        if (grants !== 1) begin
            bad++;
            $display("FAIL bp_grants: got %0d want 1", grants);
        end
        cmd_rdy = 1'b1;
        sb_cycle(g);
        total++;
        if (g !== 2) begin
            bad++;
            $display("FAIL bp_release_grant: got %0d want 2", g);
        end
        drain(5);
    endtask

    task automatic test_fifo_full();
        int g;
        int grants;
        req_v   = '1;
        cmd_rdy = 1'b1;
        resp_en = 1'b0;
        grants  = 0;
        for (int c = 0; c < 8; c++) begin
            sb_cycle(g);
            if (g >= 0) grants++;
        end
        total++;
        if (grants !== MO) begin
            bad++;
            $display("FAIL full_grants: got %0d want %0d", grants, MO);
        end
        resp_en = 1'b1;
        sb_cycle(g);
        total++;
        if (g !== -1) begin
            bad++;
            $display("FAIL full_pop_cycle: got grant %0d want none", g);
        end
        resp_en = 1'b0;
        sb_cycle(g);
        total++;
        if (g < 0) begin
            bad++;
            $display("FAIL full_after_pop: got grant %0d want one", g);
        end
        drain(8);
        total++;
        if (idle_o !== 1'b1) begin
            bad++;
            $display("FAIL full_drained_idle: got %b want 1", idle_o);
        end
    endtask

    task automatic test_orphan();
        int g;
        req_v  = '0;
        orphan = 1'b1;
        sb_cycle(g);
        orphan = 1'b0;
        for (int c = 0; c < 3; c++) sb_cycle(g);
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL orphan_sticky: got %b want 1", err_o);
        end
    endtask

    task automatic test_reset_midrun();
        int g;
        req_v   = '1;
        cmd_rdy = 1'b1;
        resp_en = 1'b0;
        for (int c = 0; c < 3; c++) sb_cycle(g);
        #2;
        reset_n_i = 1'b0;
        #1;
        total++;
        if (io_cmd_v_o !== 1'b0 || idle_o !== 1'b1 || err_o !== 1'b0 || req_cmd_yumi_o !== '0 ||
            req_resp_v_o !== '0 || io_resp_yumi_o !== 1'b0) begin
            bad++;
            $display("FAIL async_clear: got cmd_v=%b idle=%b err=%b yumi=%b rv=%b ryumi=%b want 0 1 0 0000 0000 0",
                     io_cmd_v_o, idle_o, err_o, req_cmd_yumi_o, req_resp_v_o, io_resp_yumi_o);
        end
        @(negedge clk_i);
        total++;
        if (req_cmd_yumi_o !== '0 || io_cmd_v_o !== 1'b0) begin
            bad++;
            $display("FAIL in_reset_yumi: got yumi=%b cmd_v=%b want 0000 0", req_cmd_yumi_o, io_cmd_v_o);
        end
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        model_reset();
        sb_cycle(g);
        total++;
        if (g !== 0) begin
            bad++;
            $display("FAIL first_grant_after_reset: got %0d want 0", g);
        end
        drain(6);
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_fifo_full();
        test_orphan();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
